// File: rtl/load_store_unit.sv
// Load/store front end for a word-addressed data memory: splits sub-word stores into read-modify-write
// and word-crossing accesses into two word accesses. Optional macro LSU_MISALIGN_TRAP_EN traps crossings.
module load_store_unit #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WIDTH-1:0]  req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WIDTH-1:0]  resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata
);

    localparam int BYTES  = WIDTH / 8;
    localparam int WORD_W = ADDR_W - 2;

    typedef enum logic [2:0] {IDLE, RD0, WR0, RD1, WR1, RESP} state_t;

    state_t state_reg, state_next;

    logic [ADDR_W-1:0] addr_reg;
    logic              write_reg;
    logic [2:0]        funct3_reg;
    logic [WIDTH-1:0]  wdata_reg;
    logic              err_reg;
    logic              span_reg;
    logic [WIDTH-1:0]  word0_reg;
    logic [WIDTH-1:0]  word1_reg;

    function automatic logic is_legal(input logic [2:0] f3);
        return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    endfunction

    function automatic logic is_span(input logic [2:0] f3, input logic [1:0] off);
        return ((f3[1:0] == 2'd2) && (off != 2'd0)) || ((f3[1:0] == 2'd1) && (off == 2'd3));
    endfunction

    logic req_legal;
    logic req_span;
    logic req_trap;

    assign req_legal = is_legal(req_funct3);
    assign req_span  = is_span(req_funct3, req_addr[1:0]);
`ifdef LSU_MISALIGN_TRAP_EN
    assign req_trap  = !req_legal || req_span;
`else
    assign req_trap  = !req_legal;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    if (req_trap) begin
                        state_next = RESP;
                    end else if (req_write && (req_funct3 == 3'd2) && (req_addr[1:0] == 2'd0)) begin
                        state_next = WR0;
                    end else begin
                        state_next = RD0;
                    end
                end
            end
            RD0:     state_next = write_reg ? WR0 : (span_reg ? RD1 : RESP);
            WR0:     state_next = span_reg ? RD1 : RESP;
            RD1:     state_next = write_reg ? WR1 : RESP;
            WR1:     state_next = RESP;
            RESP:    state_next = resp_ready ? IDLE : RESP;
            default: state_next = IDLE;
        endcase
    end

    // Request operands and captured memory words
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_reg   <= '0;
            write_reg  <= 1'b0;
            funct3_reg <= '0;
            wdata_reg  <= '0;
            err_reg    <= 1'b0;
            span_reg   <= 1'b0;
            word0_reg  <= '0;
            word1_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        addr_reg   <= req_addr;
                        write_reg  <= req_write;
                        funct3_reg <= req_funct3;
                        wdata_reg  <= req_wdata;
                        err_reg    <= req_trap;
                        span_reg   <= req_span;
                        word0_reg  <= '0;
                        word1_reg  <= '0;
                    end
                end
                RD0:     word0_reg <= mem_rdata;
                RD1:     word1_reg <= mem_rdata;
                default: ;
            endcase
        end
    end

    // Treat the two words as one little-endian 2*WIDTH window starting at word0
    logic [1:0]         off;
    logic [2*WIDTH-1:0] pair;
    logic [2*WIDTH-1:0] store_shift;
    logic [2*WIDTH-1:0] merged;
    logic [2*BYTES-1:0] size_mask;
    logic [2*BYTES-1:0] byte_mask;
    logic [WIDTH-1:0]   load_raw;
    logic [WIDTH-1:0]   load_ext;

    assign off         = addr_reg[1:0];
    assign pair        = {word1_reg, word0_reg};
    assign store_shift = {{WIDTH{1'b0}}, wdata_reg} << {off, 3'b000};
    assign byte_mask   = size_mask << off;
    assign load_raw    = WIDTH'(pair >> {off, 3'b000});

    always_comb begin
        size_mask = '0;
        case (funct3_reg[1:0])
            2'd0:    size_mask = 8'h01;
            2'd1:    size_mask = 8'h03;
            default: size_mask = 8'h0F;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2*BYTES; gi++) begin : g_merge
            assign merged[gi*8 +: 8] = byte_mask[gi] ? store_shift[gi*8 +: 8] : pair[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        load_ext = load_raw;
        case (funct3_reg)
            3'd0:    load_ext = {{(WIDTH-8){load_raw[7]}}, load_raw[7:0]};
            3'd1:    load_ext = {{(WIDTH-16){load_raw[15]}}, load_raw[15:0]};
            3'd4:    load_ext = {{(WIDTH-8){1'b0}}, load_raw[7:0]};
            3'd5:    load_ext = {{(WIDTH-16){1'b0}}, load_raw[15:0]};
            default: load_ext = load_raw;
        endcase
    end

    logic [WORD_W-1:0] word0_idx;
    logic [WORD_W-1:0] word1_idx;

    assign word0_idx = addr_reg[ADDR_W-1:2];
    assign word1_idx = word0_idx + WORD_W'(1);

    assign req_ready  = (state_reg == IDLE);
    assign resp_valid = (state_reg == RESP);
    assign resp_err   = (state_reg == RESP) && err_reg;
    assign resp_rdata = ((state_reg == RESP) && !write_reg && !err_reg) ? load_ext : '0;

    assign mem_read  = (state_reg == RD0) || (state_reg == RD1);
    assign mem_write = (state_reg == WR0) || (state_reg == WR1);

    always_comb begin
        mem_address = '0;
        mem_wdata   = '0;
        case (state_reg)
            RD0:     mem_address = {2'b00, word0_idx};
            RD1:     mem_address = {2'b00, word1_idx};
            WR0: begin
                mem_address = {2'b00, word0_idx};
                mem_wdata   = merged[WIDTH-1:0];
            end
            WR1: begin
                mem_address = {2'b00, word1_idx};
                mem_wdata   = merged[2*WIDTH-1:WIDTH];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases then random requests, checked against a byte-level
// reference model of memory and responses.
module tb_load_store_unit;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    load_store_unit #(.WIDTH(32), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_address(mem_address), .mem_read(mem_read),
        .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // 64-word memory; word index aliases modulo 64 in both the memory and the model
    logic [31:0] dmem    [0:63];
    logic [31:0] ref_mem [0:63];
    logic        poke_en = 1'b0;
    logic [5:0]  poke_idx = '0;
    logic [31:0] poke_data = '0;

    assign mem_rdata = dmem[mem_address[5:0]];

    always @(posedge clk) begin
        if (poke_en) dmem[poke_idx] <= poke_data;
        else if (mem_write) dmem[mem_address[5:0]] <= mem_wdata;
    end

    int          rd_cnt = 0, wr_cnt = 0, overlap = 0, hi_bad = 0, rd_mark = 0;
    logic [31:0] first_rd_addr = '0;

    always @(negedge clk) begin
        if (mem_read && rd_cnt == rd_mark) first_rd_addr = mem_address;
        if (mem_read) rd_cnt++;
        if (mem_write) wr_cnt++;
        if (mem_read && mem_write) overlap++;
        if ((mem_read || mem_write) && mem_address[31:30] != 2'b00) hi_bad++;
    end

    int tests = 0;
    int fails = 0;
    logic [31:0] last_rdata;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input int idx, input logic [31:0] data);
        poke_en = 1'b1;
        poke_idx = 6'(idx);
        poke_data = data;
        ref_mem[idx] = data;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    // Spec-level model: byte-by-byte access at byte addresses addr+k
    task automatic ref_model(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, output logic [31:0] rdata, output logic err,
                             output int lat, output int nrd, output int nwr);
        int size, off;
        bit span;
        logic [31:0] ba;
        rdata = '0; err = 1'b0; lat = 1; nrd = 0; nwr = 0;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off = int'(addr[1:0]);
        span = (off + size) > 4;
        if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (span && TRAP)) begin
            err = 1'b1;
            return;
        end
        for (int k = 0; k < size; k++) begin
            ba = addr + 32'(k);
            if (wr) ref_mem[ba[7:2]][8*int'(ba[1:0]) +: 8] = wdata[8*k +: 8];
            else rdata[8*k +: 8] = ref_mem[ba[7:2]][8*int'(ba[1:0]) +: 8];
        end
        if (!wr) begin
            if (f3 == 3'd0) rdata = {{24{rdata[7]}}, rdata[7:0]};
            if (f3 == 3'd1) rdata = {{16{rdata[15]}}, rdata[15:0]};
            lat = span ? 3 : 2;
            nrd = span ? 2 : 1;
        end else begin
            lat = span ? 5 : (size == 4 ? 2 : 3);
            nrd = span ? 2 : (size == 4 ? 0 : 1);
            nwr = span ? 2 : 1;
        end
    endtask

    task automatic do_txn(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input int hold);
        logic [31:0] e_rdata;
        logic        e_err;
        int e_lat, e_rd, e_wr, rd0, wr0, ov0, hb0, lat, diff;
        ref_model(wr, f3, addr, wdata, e_rdata, e_err, e_lat, e_rd, e_wr);
        check("req_ready", req_ready, 1);
        rd0 = rd_cnt; wr0 = wr_cnt; ov0 = overlap; hb0 = hi_bad; rd_mark = rd_cnt;
        req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, e_lat);
        check("resp_valid", resp_valid, 1);
        check("rdata", resp_rdata, e_rdata);
        check("err", resp_err, e_err);
        check("mem_reads", rd_cnt - rd0, e_rd);
        check("mem_writes", wr_cnt - wr0, e_wr);
        check("rw_overlap", overlap - ov0, 0);
        check("addr_hi_bits", hi_bad - hb0, 0);
        last_rdata = resp_rdata;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
        end
        if (hold > 0) check("resp_hold", {resp_valid, resp_err, resp_rdata}, {1'b1, e_err, e_rdata});
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("back_to_idle", {resp_valid, req_ready}, 2'b01);
        diff = 0;
        for (int i = 0; i < 64; i++) if (dmem[i] !== ref_mem[i]) diff++;
        check("mem_contents", diff, 0);
        $display("[TB] txn wr=%0d f3=%0d addr=%h wdata=%h rdata=%h err=%0d lat=%0d",
                 wr, f3, addr, wdata, last_rdata, resp_err, lat);
        if (lat >= 20) begin
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
        end
    endtask

    initial begin
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        int          r;

        rst_n = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 64; k++) poke(k, 32'(k));
        check("rst_ctrl", {resp_valid, resp_err, mem_read, mem_write, req_ready}, 5'b00001);
        check("rst_addr", mem_address, 0);
        check("rst_data", {resp_rdata, mem_wdata}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_txn(1'b0, 3'd2, 32'h8, 32'h0, 0);
        check("lw8_addr", first_rd_addr, 2);
        check("lw8_data", last_rdata, 32'h2);

        poke(1, 32'h000080FF);
        do_txn(1'b0, 3'd0, 32'h4, 32'h0, 0);
        check("lb4", last_rdata, 32'hFFFFFFFF);
        do_txn(1'b0, 3'd4, 32'h4, 32'h0, 1);
        check("lbu4", last_rdata, 32'h000000FF);
        do_txn(1'b0, 3'd1, 32'h5, 32'h0, 0);
        check("lh5", last_rdata, 32'h00000080);
        do_txn(1'b0, 3'd1, 32'h4, 32'h0, 0);
        check("lh4", last_rdata, 32'hFFFF80FF);

        do_txn(1'b1, 3'd0, 32'h9, 32'hAB, 0);
        check("sb9_word2", dmem[2], 32'h0000AB02);

        poke(1, 32'h1);
        do_txn(1'b1, 3'd2, 32'h6, 32'hDDCCBBAA, 2);
        check("sw6_word1", dmem[1], TRAP ? 32'h00000001 : 32'hBBAA0001);
        check("sw6_word2", dmem[2], TRAP ? 32'h0000AB02 : 32'h0000DDCC);

        do_txn(1'b0, 3'd3, 32'h10, 32'h0, 4);
        do_txn(1'b1, 3'd7, 32'h14, 32'h12345678, 1);
        do_txn(1'b0, 3'd2, 32'hFFFFFFFE, 32'h0, 0);
        do_txn(1'b1, 3'd1, 32'hFFFFFFFF, 32'h0000BEEF, 0);

        // Reset in the middle of a word-crossing load
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h6;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("rd1_read", mem_read, !TRAP);
        check("rd1_addr", mem_address, TRAP ? 32'h0 : 32'h2);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_ctrl", {resp_valid, resp_err, mem_read, mem_write, req_ready}, 5'b00001);
        check("midrst_addr", mem_address, 0);
        check("midrst_data", {resp_rdata, mem_wdata}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_txn(1'b0, 3'd2, 32'h8, 32'h0, 0);

        for (int n = 0; n < 40; n++) begin
            wr = 1'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                f3 = ($urandom_range(0, 1) == 0) ? 3'd3 : 3'(6 + $urandom_range(0, 1));
            end else if (wr) begin
                f3 = 3'($urandom_range(0, 2));
            end else begin
                f3 = 3'($urandom_range(0, 4));
                if (f3 == 3'd3) f3 = 3'd5;
            end
            if ($urandom_range(0, 15) == 0) addr = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
            else addr = 32'($urandom_range(0, 255));
            do_txn(wr, f3, addr, $urandom, int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
